// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Multiplies by shift-add and divides by restoring division, one bit per cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic [1:0]       opCode,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic             writeHi,
  input  logic             writeLo,
  input  logic [WIDTH-1:0] writeData,
  output logic             busy,
  output logic             done,
  output logic             divByZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               r_state;
  logic                 r_isDiv;
  logic                 r_negRes;
  logic                 r_negRem;
  logic                 r_divZero;
  logic [WIDTH-1:0]     r_opnd1;
  logic [WIDTH-1:0]     r_m;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_count;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_dbz;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  logic                 w_isDiv;
  logic                 w_neg1;
  logic                 w_neg2;
  logic [WIDTH-1:0]     w_mag1;
  logic [WIDTH-1:0]     w_mag2;
  logic [WIDTH:0]       w_addSum;
  logic [WIDTH:0]       w_remShift;
  logic [WIDTH:0]       w_diff;
  logic [2*WIDTH-1:0]   w_stepAcc;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quo;
  logic [WIDTH-1:0]     w_rem;

  assign w_isDiv = opCode[1];
  assign w_neg1  = ~opCode[0] & operand1[WIDTH-1];
  assign w_neg2  = ~opCode[0] & operand2[WIDTH-1];
  assign w_mag1  = w_neg1 ? -operand1 : operand1;
  assign w_mag2  = w_neg2 ? -operand2 : operand2;

  // Multiply: upper half accumulates the multiplicand, the whole pair shifts right.
  assign w_addSum = r_acc[0] ? ({1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_m})
                             : {1'b0, r_acc[2*WIDTH-1:WIDTH]};

  // Divide: remainder in the upper half, dividend shifts out as quotient shifts in.
  assign w_remShift = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff     = w_remShift - {1'b0, r_m};

  assign w_stepAcc = !r_isDiv  ? {w_addSum, r_acc[WIDTH-1:1]} :
                     w_diff[WIDTH] ? {w_remShift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                   : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_prod = r_negRes ? -r_acc : r_acc;
  assign w_quo  = r_negRes ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_negRem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state   <= IDLE;
      r_isDiv   <= 1'b0;
      r_negRes  <= 1'b0;
      r_negRem  <= 1'b0;
      r_divZero <= 1'b0;
      r_opnd1   <= '0;
      r_m       <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dbz     <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_isDiv   <= w_isDiv;
            r_negRes  <= w_neg1 ^ w_neg2;
            r_negRem  <= w_neg1;
            r_divZero <= w_isDiv && (operand2 == '0);
            r_opnd1   <= operand1;
            r_m       <= w_isDiv ? w_mag2 : w_mag1;
            r_acc     <= {{WIDTH{1'b0}}, (w_isDiv ? w_mag1 : w_mag2)};
            r_count   <= CW'(WIDTH);
            r_busy    <= 1'b1;
            r_state   <= (w_isDiv && (operand2 == '0)) ? FIX : RUN;
          end else begin
            if (writeHi) r_hi <= writeData;
            if (writeLo) r_lo <= writeData;
          end
        end
        RUN: begin
          r_acc   <= w_stepAcc;
          r_count <= r_count - CW'(1);
          if (r_count == CW'(1)) r_state <= FIX;
        end
        FIX: begin
          if (r_divZero) begin
            r_hi  <= r_opnd1;
            r_lo  <= '1;
            r_dbz <= 1'b1;
          end else if (r_isDiv) begin
            r_hi  <= w_rem;
            r_lo  <= w_quo;
            r_dbz <= 1'b0;
          end else begin
            r_hi  <= w_prod[2*WIDTH-1:WIDTH];
            r_lo  <= w_prod[WIDTH-1:0];
            r_dbz <= 1'b0;
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign divByZero = r_dbz;
  assign hi        = r_hi;
  assign lo        = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;

  localparam int WIDTH = 32;

  logic             clk;
  logic             resetN;
  logic             start;
  logic [1:0]       opCode;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic             writeHi;
  logic             writeLo;
  logic [WIDTH-1:0] writeData;
  logic             busy;
  logic             done;
  logic             divByZero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int vectors;
  int miscompares;

  mult_div_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .resetN(resetN), .start(start), .opCode(opCode),
    .operand1(operand1), .operand2(operand2), .writeHi(writeHi),
    .writeLo(writeLo), .writeData(writeData), .busy(busy), .done(done),
    .divByZero(divByZero), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model straight from the arithmetic definitions of each op.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eHi, output logic [31:0] eLo,
                       output logic eDbz, output int eLat);
    logic [63:0] p;
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    eDbz = 1'b0;
    eLat = WIDTH + 1;
    case (op)
      2'b00: begin p = longint'(sa) * longint'(sb); {eHi, eLo} = p; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; {eHi, eLo} = p; end
      default: begin
        if (b == 0) begin
          eHi = a; eLo = 32'hFFFF_FFFF; eDbz = 1'b1; eLat = 1;
        end else if (op == 2'b11) begin
          eLo = a / b; eHi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          eLo = 32'h8000_0000; eHi = 32'h0;
        end else begin
          eLo = sa / sb; eHi = sa % sb;
        end
      end
    endcase
  endtask

  // Starts an op in the current cycle and follows it to its done pulse.
  task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input bit disturb, input bit withWriteLo);
    logic [31:0] eHi, eLo, prevHi, prevLo;
    logic eDbz;
    int eLat, n;
    model(op, a, b, eHi, eLo, eDbz, eLat);
    prevHi = hi;
    prevLo = lo;
    start = 1'b1; opCode = op; operand1 = a; operand2 = b;
    writeLo = withWriteLo; writeData = 32'h1234_5678;
    @(posedge clk); #1;
    start = 1'b0; writeLo = 1'b0;
    operand1 = $urandom; operand2 = $urandom; opCode = 2'($urandom_range(0, 3));
    checkOutput({tag, "_busyE0"}, 64'(busy), 64'(1));
    checkOutput({tag, "_loHeld"}, 64'(lo), 64'(prevLo));
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (disturb && n == 5) begin
        start = 1'b1; writeHi = 1'b1; writeData = $urandom;
      end else if (disturb && n == 6) begin
        start = 1'b0; writeHi = 1'b0;
        checkOutput({tag, "_hiHeld"}, 64'(hi), 64'(prevHi));
      end
    end while (!done && n < 100);
    checkOutput({tag, "_latency"}, 64'(n), 64'(eLat));
    checkOutput({tag, "_hi"}, 64'(hi), 64'(eHi));
    checkOutput({tag, "_lo"}, 64'(lo), 64'(eLo));
    checkOutput({tag, "_dbz"}, 64'(divByZero), 64'(eDbz));
    checkOutput({tag, "_busyDone"}, 64'(busy), 64'(0));
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    resetN = 1'b0; start = 1'b0; opCode = 2'b00; operand1 = '0; operand2 = '0;
    writeHi = 1'b0; writeLo = 1'b0; writeData = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_hi", 64'(hi), 64'(0));
    checkOutput("rst_lo", 64'(lo), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_done", 64'(done), 64'(0));
    checkOutput("rst_dbz", 64'(divByZero), 64'(0));
    resetN = 1'b1;
    @(posedge clk); #1;

    applyStimulus("multuMax", 2'b01, 32'hFFFF_FFFF, 32'h2, 1'b0, 1'b0);
    applyStimulus("multNeg", 2'b00, 32'hFFFF_FFFD, 32'h5, 1'b0, 1'b0);
    applyStimulus("multMin", 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    applyStimulus("divNeg", 2'b10, 32'hFFFF_FFF9, 32'h2, 1'b0, 1'b0);
    applyStimulus("divOvf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    applyStimulus("divu", 2'b11, 32'd100, 32'd7, 1'b0, 1'b0);
    applyStimulus("divZero", 2'b11, 32'd5, 32'd0, 1'b0, 1'b0);
    applyStimulus("dbzClear", 2'b01, 32'd3, 32'd3, 1'b0, 1'b0);
    applyStimulus("busyIgnore", 2'b01, 32'h0001_2345, 32'h0006_789A, 1'b1, 1'b0);

    writeHi = 1'b1; writeLo = 1'b1; writeData = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    writeHi = 1'b0; writeLo = 1'b0;
    checkOutput("mthi", 64'(hi), 64'(32'hA5A5_A5A5));
    checkOutput("mtlo", 64'(lo), 64'(32'hA5A5_A5A5));

    applyStimulus("startWins", 2'b11, 32'd100, 32'd7, 1'b0, 1'b1);
    applyStimulus("preReset", 2'b00, 32'hFFFF_FFFD, 32'h5, 1'b0, 1'b0);

    start = 1'b1; opCode = 2'b01; operand1 = 32'hDEAD_BEEF; operand2 = 32'h1234_5678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    resetN = 1'b0;
    #1;
    checkOutput("midRst_busy", 64'(busy), 64'(0));
    checkOutput("midRst_done", 64'(done), 64'(0));
    checkOutput("midRst_hi", 64'(hi), 64'(0));
    checkOutput("midRst_lo", 64'(lo), 64'(0));
    @(posedge clk); #1;
    resetN = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      checkOutput("noDoneAfterRst", 64'(done), 64'(0));
    end

    applyStimulus("postReset", 2'b00, 32'd7, 32'hFFFF_FFF7, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      applyStimulus("random", rop, ra, rb, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
